// File: rtl/jtsdram_chk_pkg.sv
// Shared definitions for the multi-channel SDRAM checker.
//   chk_state_e   : per-channel FSM states
//   LFSR_TAPS     : feedback taps of x^16+x^14+x^13+x^11+1 (Fibonacci, shift left)
//   SEED_ZERO_SUB : seed used instead of an all-zero key (zero would lock the LFSR)
//   lfsr_next     : one LFSR step
//   seed_fix      : key-to-seed conversion applied at start
package jtsdram_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    DONE
  } chk_state_e;

  // Taps at bits 15,13,12,10 of the shift-left register.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] SEED_ZERO_SUB = 16'h0001;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] seed_fix(input logic [15:0] k);
    return (k == 16'h0000) ? SEED_ZERO_SUB : k;
  endfunction

endpackage

// File: rtl/jtsdram_multicheck_if.sv
// Channel-side bus between the checker and the SDRAM controller bank ports.
//   master : checker (drives address/read/write/data, receives ack/rdy/read bus)
//   slave  : controller
// Channel i occupies slice i of every packed vector; data_read is shared.
interface jtsdram_multicheck_if #(
  parameter int NCH = 4,
  parameter int AW  = 22
);
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_rd;
  logic [NCH-1:0]    ch_wr;
  logic [NCH*16-1:0] ch_din;
  logic [NCH-1:0]    ch_ack;
  logic [NCH-1:0]    ch_rdy;
  logic [31:0]       data_read;

  modport master (
    output ch_addr, ch_rd, ch_wr, ch_din,
    input  ch_ack, ch_rdy, data_read
  );

  modport slave (
    input  ch_addr, ch_rd, ch_wr, ch_din,
    output ch_ack, ch_rdy, data_read
  );
endinterface

// File: rtl/jtsdram_chk_ch.sv
// One checker channel: FSM, LFSR reference generator, word index and
// saturating error counter.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start, rw_mode  : begin a pass (only honoured in IDLE); write+read or read-only
//   key, base       : LFSR seed and start address, captured at start
//   hold            : blocks raising a new request; a raised one stays up
//   release_all     : every channel reached DONE; return to IDLE
//   addr/rd/wr/din  : request to the controller (zero when no request is up)
//   ack, rdy, rdata : controller accept, completion, low 16 bits of read bus
//   active/finished : channel is mid-pass / waiting in DONE
//   bad, err_cnt    : sticky mismatch flag and saturating mismatch count
// Optional (JTSDRAM_ERRLOG_EN): first_addr/first_data of the first mismatch.
module jtsdram_chk_ch
  import jtsdram_chk_pkg::*;
#(
  parameter int AW   = 22,
  parameter int LEN  = 4096,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            rw_mode,
  input  logic [15:0]     key,
  input  logic [AW-1:0]   base,
  input  logic            hold,
  input  logic            release_all,
  output logic [AW-1:0]   addr,
  output logic            rd,
  output logic            wr,
  output logic [15:0]     din,
  input  logic            ack,
  input  logic            rdy,
  input  logic [15:0]     rdata,
  output logic            active,
  output logic            finished,
  output logic            bad,
  output logic [ERRW-1:0] err_cnt
`ifdef JTSDRAM_ERRLOG_EN
  ,
  output logic [AW-1:0]   first_addr,
  output logic [15:0]     first_data
`endif
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  chk_state_e      state_q, state_d;
  logic [15:0]     lfsr_q, key_q;
  logic [AW-1:0]   base_q;
  logic [IW-1:0]   idx_q;
  logic            rd_q, wr_q, bad_q;
  logic [ERRW-1:0] err_q;
  logic            load, raise, drop, beat, last, wr_phase, mismatch;
  logic [AW-1:0]   cur_addr;
`ifdef JTSDRAM_ERRLOG_EN
  logic [AW-1:0]   first_addr_q;
  logic [15:0]     first_data_q;
`endif

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    raise    = 1'b0;
    drop     = 1'b0;
    beat     = 1'b0;
    wr_phase = (state_q == WR_REQ) || (state_q == WR_WAIT);
    last     = (idx_q == LAST);
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = rw_mode ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        if (!(rd_q || wr_q)) begin
          raise = !hold;
        end else if (ack) begin
          // rdy without a prior ack is ignored; rdy together with ack is a full beat
          drop = 1'b1;
          beat = rdy;
          if (!rdy) state_d = wr_phase ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: beat = rdy;
      DONE: begin
        if (release_all) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (beat) begin
      if (wr_phase) state_d = last ? RD_REQ : WR_REQ;
      else          state_d = last ? DONE : RD_REQ;
    end
    mismatch = beat && !wr_phase && (rdata != lfsr_q);
  end

  // Address wraps silently modulo 2**AW.
  assign cur_addr = base_q + AW'(idx_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED_ZERO_SUB;
      key_q  <= SEED_ZERO_SUB;
      base_q <= '0;
      idx_q  <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      bad_q  <= 1'b0;
      err_q  <= '0;
`ifdef JTSDRAM_ERRLOG_EN
      first_addr_q <= '0;
      first_data_q <= '0;
`endif
    end else begin
      if (load) begin
        key_q  <= seed_fix(key);
        lfsr_q <= seed_fix(key);
        base_q <= base;
        idx_q  <= '0;
        bad_q  <= 1'b0;
        err_q  <= '0;
`ifdef JTSDRAM_ERRLOG_EN
        first_addr_q <= '0;
        first_data_q <= '0;
`endif
      end
      if (raise) begin
        rd_q <= !wr_phase;
        wr_q <= wr_phase;
      end else if (drop) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
      if (beat) begin
        // End of a pass restarts the reference sequence for the verify pass.
        if (last) begin
          idx_q  <= '0;
          lfsr_q <= key_q;
        end else begin
          idx_q  <= idx_q + IW'(1);
          lfsr_q <= lfsr_next(lfsr_q);
        end
        if (mismatch) begin
          bad_q <= 1'b1;
          err_q <= sat_inc(err_q);
`ifdef JTSDRAM_ERRLOG_EN
          if (!bad_q) begin
            first_addr_q <= cur_addr;
            first_data_q <= rdata;
          end
`endif
        end
      end
    end
  end

  assign addr     = (rd_q || wr_q) ? cur_addr : '0;
  assign rd       = rd_q;
  assign wr       = wr_q;
  assign din      = wr_q ? lfsr_q : 16'h0000;
  assign active   = (state_q != IDLE) && (state_q != DONE);
  assign finished = (state_q == DONE);
  assign bad      = bad_q;
  assign err_cnt  = err_q;
`ifdef JTSDRAM_ERRLOG_EN
  assign first_addr = first_addr_q;
  assign first_data = first_data_q;
`endif

endmodule

// File: rtl/jtsdram_multicheck.sv
// Multi-channel SDRAM write/verify checker. Channel i drives SDRAM bank i.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : one-cycle pulse, begins a pass on all channels (ignored while busy)
//   rw_mode     : 1 write-then-verify, 0 verify only (sampled at start)
//   key, base   : per-channel LFSR seed / start address (sampled at start)
//   hold        : blanking gate, no new requests while high
//   bus         : channel request/handshake bus (jtsdram_multicheck_if.master)
//   busy, done  : any channel running / one-cycle pulse when all channels finish
//   bad, err_cnt: per-channel sticky mismatch flag and saturating count
// Optional build macro JTSDRAM_ERRLOG_EN adds first_addr/first_data, the address
// and read data of each channel's first mismatch.
module jtsdram_multicheck #(
  parameter int NCH  = 4,
  parameter int AW   = 22,
  parameter int LEN  = 4096,
  parameter int ERRW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                rw_mode,
  input  logic [NCH*16-1:0]   key,
  input  logic [NCH*AW-1:0]   base,
  input  logic                hold,
  jtsdram_multicheck_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [NCH-1:0]      bad,
  output logic [NCH*ERRW-1:0] err_cnt
`ifdef JTSDRAM_ERRLOG_EN
  ,
  output logic [NCH*AW-1:0]   first_addr,
  output logic [NCH*16-1:0]   first_data
`endif
);

  logic [NCH*AW-1:0] addr_v;
  logic [NCH-1:0]    rd_v, wr_v, active_v, finished_v;
  logic [NCH*16-1:0] din_v;
  logic              start_ok, all_done;
  logic              unused_rd_hi;

  assign start_ok     = start && !busy;
  assign all_done     = &finished_v;
  assign unused_rd_hi = ^bus.data_read[31:16];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    jtsdram_chk_ch #(
      .AW   (AW),
      .LEN  (LEN),
      .ERRW (ERRW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_ok),
      .rw_mode     (rw_mode),
      .key         (key[i*16 +: 16]),
      .base        (base[i*AW +: AW]),
      .hold        (hold),
      .release_all (all_done),
      .addr        (addr_v[i*AW +: AW]),
      .rd          (rd_v[i]),
      .wr          (wr_v[i]),
      .din         (din_v[i*16 +: 16]),
      .ack         (bus.ch_ack[i]),
      .rdy         (bus.ch_rdy[i]),
      .rdata       (bus.data_read[15:0]),
      .active      (active_v[i]),
      .finished    (finished_v[i]),
      .bad         (bad[i]),
      .err_cnt     (err_cnt[i*ERRW +: ERRW])
`ifdef JTSDRAM_ERRLOG_EN
      ,
      .first_addr  (first_addr[i*AW +: AW]),
      .first_data  (first_data[i*16 +: 16])
`endif
    );
  end

  assign bus.ch_addr = addr_v;
  assign bus.ch_rd   = rd_v;
  assign bus.ch_wr   = wr_v;
  assign bus.ch_din  = din_v;
  assign busy        = |active_v;
  // Channels leave DONE the cycle after all_done, so this is a single-cycle pulse.
  assign done        = all_done;

endmodule
